// File: rtl/fp_result_norm_pipe_if.sv
// Bundle of handshake, payload and flag signals between the significand adder,
// the result normaliser and the sign/pack writeback.
interface fp_result_norm_pipe_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES-1:0]              in_op;
  logic [LANES-1:0]              in_large_expff;
  logic [LANES-1:0]              in_large_frac00;
  logic [LANES-1:0]              in_small_expff;
  logic [LANES-1:0]              in_small_frac00;
  logic [LANES*EXP_W-1:0]        in_exp;
  logic [LANES*(FRAC_W+2)-1:0]   in_mant;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*EXP_W-1:0]        out_expo;
  logic [LANES*FRAC_W-1:0]       out_frac;
  logic                          flag_clr;
  logic [LANES*3-1:0]            sticky_flags;

  modport master (
    output in_valid, in_op, in_large_expff, in_large_frac00, in_small_expff,
           in_small_frac00, in_exp, in_mant, out_ready, flag_clr,
    input  in_ready, out_valid, out_expo, out_frac, sticky_flags
  );

  modport slave (
    input  in_valid, in_op, in_large_expff, in_large_frac00, in_small_expff,
           in_small_frac00, in_exp, in_mant, out_ready, flag_clr,
    output in_ready, out_valid, out_expo, out_frac, sticky_flags
  );
endinterface

// File: rtl/fp_result_norm_pipe.sv
// Two-stage valid/ready normaliser: raw adder output plus operand classes in,
// packed exponent/fraction with NaN/Inf/overflow/subnormal handling out.
module fp_result_norm_pipe #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_result_norm_pipe_if.slave bus
);
  localparam int unsigned MANT_W = FRAC_W + 2;
  localparam int unsigned LZ_W   = $clog2(FRAC_W + 2);
  localparam int unsigned EW     = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic                    in_ready_c;
  logic                    s1_valid, s2_valid, s2_ready, xfer;
  logic [LANES-1:0]        l_inf, l_nan, s_inf, s_nan, c_inv, c_nan, c_inf;
  logic [EXP_W-1:0]        c_exp   [LANES];
  logic [LZ_W-1:0]         c_lz    [LANES];
  logic [LANES-1:0]        s1_nan, s1_inf, s1_inv;
  logic [EXP_W-1:0]        s1_exp  [LANES];
  logic [MANT_W-1:0]       s1_mant [LANES];
  logic [LZ_W-1:0]         s1_lz   [LANES];
  logic [EXP_W-1:0]        r_expo  [LANES];
  logic [FRAC_W-1:0]       r_frac  [LANES];
  logic [FRAC_W:0]         r_shift [LANES];
  logic [EW-1:0]           r_einc  [LANES];
  logic [LANES-1:0]        r_ovf, r_unf;
  logic [LANES-1:0]        s2_inv, s2_ovf, s2_unf;
  logic [LANES*EXP_W-1:0]  expo_q;
  logic [LANES*FRAC_W-1:0] frac_q;
  logic [LANES*3-1:0]      sticky_q;

  assign s2_ready         = ~s2_valid | bus.out_ready;
  assign in_ready_c       = ~s1_valid | s2_ready;
  assign xfer             = s2_valid & bus.out_ready;
  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = s2_valid;
  assign bus.out_expo     = expo_q;
  assign bus.out_frac     = frac_q;
  assign bus.sticky_flags = sticky_q;

  // Operand classification; an inf-minus-inf is both invalid and NaN.
  assign l_inf = bus.in_large_expff & bus.in_large_frac00;
  assign l_nan = bus.in_large_expff & ~bus.in_large_frac00;
  assign s_inf = bus.in_small_expff & bus.in_small_frac00;
  assign s_nan = bus.in_small_expff & ~bus.in_small_frac00;
  assign c_inv = bus.in_op & l_inf & s_inf;
  assign c_nan = l_nan | s_nan | c_inv;
  assign c_inf = ~c_nan & (l_inf | s_inf);

  // Zero exponent acts as 1; leading-zero count over {hidden, fraction}.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      c_exp[i] = (bus.in_exp[i*EXP_W +: EXP_W] == '0) ? EXP_W'(1)
                                                       : bus.in_exp[i*EXP_W +: EXP_W];
      c_lz[i]  = LZ_W'(FRAC_W + 1);
      for (int b = 0; b <= FRAC_W; b++) begin
        if (bus.in_mant[i*MANT_W + b]) c_lz[i] = LZ_W'(FRAC_W - b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_nan   <= '0;
      s1_inf   <= '0;
      s1_inv   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_exp[i]  <= '0;
        s1_mant[i] <= '0;
        s1_lz[i]   <= '0;
      end
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_nan <= c_nan;
        s1_inf <= c_inf;
        s1_inv <= c_inv;
        for (int i = 0; i < LANES; i++) begin
          s1_exp[i]  <= c_exp[i];
          s1_mant[i] <= bus.in_mant[i*MANT_W +: MANT_W];
          s1_lz[i]   <= c_lz[i];
        end
      end
    end
  end

  // Result selection in priority order: NaN, Inf, zero, carry, normal, subnormal.
  always_comb begin
    r_ovf = '0;
    r_unf = '0;
    for (int i = 0; i < LANES; i++) begin
      r_expo[i]  = '0;
      r_frac[i]  = '0;
      r_shift[i] = '0;
      r_einc[i]  = EW'(s1_exp[i]) + EW'(1);
      if (s1_nan[i]) begin
        r_expo[i] = EXP_ONES;
        r_frac[i] = '1;
      end else if (s1_inf[i]) begin
        r_expo[i] = EXP_ONES;
      end else if (s1_mant[i] == '0) begin
        r_expo[i] = '0;
      end else if (s1_mant[i][MANT_W-1]) begin
        if (r_einc[i] >= EW'(EXP_ONES)) begin
          r_expo[i] = EXP_ONES;
          r_ovf[i]  = 1'b1;
        end else begin
          r_expo[i] = EXP_W'(r_einc[i]);
          r_frac[i] = s1_mant[i][FRAC_W:1];
        end
      end else if (s1_exp[i] == EXP_ONES) begin
        r_expo[i] = EXP_ONES;
        r_ovf[i]  = 1'b1;
      end else if (EW'(s1_exp[i]) > EW'(s1_lz[i])) begin
        r_shift[i] = s1_mant[i][FRAC_W:0] << s1_lz[i];
        r_expo[i]  = EXP_W'(EW'(s1_exp[i]) - EW'(s1_lz[i]));
        r_frac[i]  = r_shift[i][FRAC_W-1:0];
      end else begin
        r_shift[i] = s1_mant[i][FRAC_W:0] << (s1_exp[i] - EXP_W'(1));
        r_frac[i]  = r_shift[i][FRAC_W-1:0];
        r_unf[i]   = |r_shift[i][FRAC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inv   <= '0;
      s2_ovf   <= '0;
      s2_unf   <= '0;
      expo_q   <= '0;
      frac_q   <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inv <= s1_inv;
        s2_ovf <= r_ovf;
        s2_unf <= r_unf;
        for (int i = 0; i < LANES; i++) begin
          expo_q[i*EXP_W +: EXP_W]   <= r_expo[i];
          frac_q[i*FRAC_W +: FRAC_W] <= r_frac[i];
        end
      end
    end
  end

  // Sticky {underflow, overflow, invalid} per lane; a same-cycle set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        sticky_q[i*3 +: 3] <= (bus.flag_clr ? 3'b000 : sticky_q[i*3 +: 3]) |
                              (xfer ? {s2_unf[i], s2_ovf[i], s2_inv[i]} : 3'b000);
      end
    end
  end
endmodule

// File: doc/fp_result_norm_pipe.md
# fp_result_norm_pipe

Parametrised, pipelined successor to the floating-point add/sub result-and-exception stage. It accepts LANES independent lanes of unnormalised adder output, plus operand class bits, and produces packed exponent/fraction fields with NaN/infinity/overflow/subnormal handling. It adds an internal leading-zero count, a 2-stage valid/ready pipeline and sticky exception flags. It sits between the significand adder and the sign/pack writeback.

## Interface
- LANES, 2, number of independent lanes
- EXP_W, 8, biased exponent width
- FRAC_W, 23, stored fraction width (hidden bit excluded)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_op  in  LANES  per lane: 1 = effective subtract
- in_large_expff, in_large_frac00, in_small_expff, in_small_frac00  in  LANES each  operand class bits: exp all-ones / fraction zero
- in_exp  in  LANES*EXP_W  biased exponent of the hidden-bit position
- in_mant  in  LANES*(FRAC_W+2)  per lane: {carry, hidden, fraction}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_expo  out  LANES*EXP_W  result exponent
- out_frac  out  LANES*FRAC_W  result fraction
- flag_clr  in  1  synchronous clear of sticky flags
- sticky_flags  out  LANES*3  per lane {underflow, overflow, invalid}

## Operation
- Lane i uses slices [i*W +: W]. Lanes never interact.
- Class:
  - large_inf = expff&frac00; large_nan = expff&~frac00; same for small.
  - nan = large_nan | small_nan | (op & large_inf & small_inf).
  - invalid = op & large_inf & small_inf.
  - inf = ~nan & (large_inf | small_inf).
- Stage 1 registers: class bits, in_exp (treated as 1 when 0), mant, and lz = leading-zero count of mant[FRAC_W:0] (0..FRAC_W+1).
- Stage 2 selects the result in priority order:
  - nan: expo all-ones, frac all-ones.
  - inf: expo all-ones, frac 0.
  - mant == 0: expo 0, frac 0.
  - mant[FRAC_W+1] == 1 (carry): e = exp+1, frac = mant[FRAC_W:1] (truncate). If e >= all-ones, overflow: expo all-ones, frac 0.
  - exp > lz (normal): shift left lz; expo = exp-lz; frac = low FRAC_W bits.
  - exp <= lz (subnormal): shift left exp-1; expo 0; frac = low FRAC_W bits; underflow event if frac != 0.
  - Non-special input with exp all-ones and no carry: overflow.
- Sticky flags:
  - Set by invalid, overflow and underflow events when the beat transfers out (out_valid & out_ready).
  - flag_clr zeroes them.
  - If clear and set occur in the same cycle, set wins.
- Arithmetic: exponent add/subtract uses EXP_W+1 bits so wrap cannot occur; shifts are logical and zero-filling.

## Timing
- Latency: 2 cycles from input handshake to out_valid.
- Throughput: 1 beat/cycle.
- Readiness:
  - s2_ready = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_ready (combinational, no bubble).
- Each stage loads when its valid is low or downstream consumes. Data is held stable while out_valid & ~out_ready.
- Ordering is strictly FIFO. There are no drops or duplicates under any backpressure pattern.
- Reset (asynchronous, any time, including mid-flight):
  - s1_valid, s2_valid, out_valid, out_expo, out_frac and sticky_flags go to 0.
  - In-flight beats are discarded.
  - in_ready is 1 from the first cycle after rst_n rises.

## Test plan
All scenarios use LANES=2, EXP_W=8, FRAC_W=23.
- Normal: lane0 mant=25'h0400000, exp=8'd10 (lz=1) -> 2 cycles later expo=8'd9, frac=0, no flags. Lane1 mant=25'h0800001, exp=8'd20 -> expo=8'd20, frac=23'h000001.
- Carry/overflow:
  - mant=25'h1800000, exp=8'd5 -> expo=8'd6, frac=23'h400000.
  - Same mant with exp=8'hFE -> expo=8'hFF, frac=0, sticky overflow set.
- Subnormal: mant=25'h0000100, exp=8'd3 (lz=15) -> expo=0, frac=23'h000400, sticky underflow set.
- Exceptions:
  - op=1 with both operands inf -> expo=8'hFF, frac=23'h7FFFFF, sticky invalid. The other lane's result is unaffected.
  - op=0 with both operands inf -> infinity, no invalid.
  - Then flag_clr clears the flags. Assert flag_clr in the same cycle as a new overflow transfer -> overflow flag = 1.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted beats. The 4 results emerge in order, with values held while stalled.
- Reset: pull rst_n low with 2 beats in flight -> out_valid=0 and sticky_flags=0 immediately. After release, no stale beats emerge.
